// File: rtl/conv_sched_pkg.sv
// Shared types and default widths for the convolution job scheduler.
// The FIFO entry packs {id, x, y, z}, so its width derives from the address and id widths.
package conv_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_REPORT = 2'd3
  } sched_state_e;

  localparam int ADDR_W_DEF = 7;
  localparam int DEPTH_DEF  = 4;
  localparam int ID_W_DEF   = 4;
  localparam int CYC_W_DEF  = 16;

  function automatic int entry_w(input int addr_w, input int id_w);
    return 3 * addr_w + id_w;
  endfunction

endpackage

// File: rtl/conv_job_scheduler_fifo.sv
// Show-ahead synchronous FIFO holding queued jobs; rd_data is the current head entry.
// Pushing when full and popping when empty are both ignored.
module job_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/conv_job_scheduler.sv
// Queues convolution jobs, launches them one at a time on the engine and reports
// one completion record (id, measured engine cycles) per job.
//
// state  | meaning
// IDLE   | wait for a queued job; pop it into the hold registers
// LAUNCH | conv_start pulse, clear cycle counter
// WAIT   | count engine cycles until a fresh rising edge of conv_done
// REPORT | present completion record until cmp_ready
module conv_job_scheduler
  import conv_sched_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ID_W   = ID_W_DEF,
  parameter int CYC_W  = CYC_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_W-1:0]      req_x,
  input  logic [ADDR_W-1:0]      req_y,
  input  logic [ADDR_W-1:0]      req_z,
  output logic                   conv_start,
  output logic [ADDR_W-1:0]      conv_x,
  output logic [ADDR_W-1:0]      conv_y,
  output logic [ADDR_W-1:0]      conv_z,
  input  logic                   conv_done,
  output logic                   cmp_valid,
  input  logic                   cmp_ready,
  output logic [ID_W-1:0]        cmp_id,
  output logic [CYC_W-1:0]       cmp_cycles,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] queue_count
);

  localparam int ENTRY_W = entry_w(ADDR_W, ID_W);

  sched_state_e     state;
  logic [ID_W-1:0]  next_id;
  logic [CYC_W-1:0] cyc_cnt;
  logic [CYC_W-1:0] cyc_inc;
  logic             done_q;
  logic             done_rise;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;

  assign req_ready = ~fifo_full;
  assign push      = req_valid & req_ready;
  assign pop       = (state == ST_IDLE) & ~fifo_empty;
  assign done_rise = conv_done & ~done_q;
  assign cyc_inc   = (cyc_cnt == {CYC_W{1'b1}}) ? cyc_cnt : cyc_cnt + CYC_W'(1);

  job_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push    (push),
    .pop     (pop),
    .wr_data ({next_id, req_x, req_y, req_z}),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (queue_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      next_id <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= conv_done;
      if (push) next_id <= next_id + 1'b1;
    end
  end

  // cmp_id doubles as the held id of the running job; it is only observed in REPORT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      conv_start <= 1'b0;
      cmp_valid  <= 1'b0;
      busy       <= 1'b0;
      conv_x     <= '0;
      conv_y     <= '0;
      conv_z     <= '0;
      cmp_id     <= '0;
      cyc_cnt    <= '0;
      cmp_cycles <= '0;
    end else begin
      conv_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            {cmp_id, conv_x, conv_y, conv_z} <= fifo_head;
            conv_start <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          cyc_cnt <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_rise) begin
            cmp_cycles <= cyc_inc;
            cmp_valid  <= 1'b1;
            state      <= ST_REPORT;
          end else begin
            cyc_cnt <= cyc_inc;
          end
        end
        ST_REPORT: begin
          if (cmp_ready) begin
            cmp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_job_scheduler.sv
// Directed bench for conv_job_scheduler: default instance plus a narrow
// instance (ID_W=2, CYC_W=4) for id wrap and cycle-count saturation.
module tb_conv_job_scheduler;

  logic       clk;
  logic       rst;

  logic       req_valid, req_ready, conv_start, conv_done, cmp_valid, cmp_ready, busy;
  logic [6:0] req_x, req_y, req_z, conv_x, conv_y, conv_z;
  logic [3:0] cmp_id;
  logic [15:0] cmp_cycles;
  logic [2:0] queue_count;

  logic       req_valid_s, req_ready_s, conv_start_s, conv_done_s, cmp_valid_s, cmp_ready_s, busy_s;
  logic [6:0] req_x_s, req_y_s, req_z_s, conv_x_s, conv_y_s, conv_z_s;
  logic [1:0] cmp_id_s;
  logic [3:0] cmp_cycles_s;
  logic [2:0] queue_count_s;

  int checks = 0;
  int failures = 0;

  conv_job_scheduler dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .conv_start(conv_start), .conv_x(conv_x), .conv_y(conv_y), .conv_z(conv_z),
    .conv_done(conv_done),
    .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_id(cmp_id), .cmp_cycles(cmp_cycles),
    .busy(busy), .queue_count(queue_count)
  );

  conv_job_scheduler #(.ID_W(2), .CYC_W(4)) dut_s (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_s), .req_ready(req_ready_s),
    .req_x(req_x_s), .req_y(req_y_s), .req_z(req_z_s),
    .conv_start(conv_start_s), .conv_x(conv_x_s), .conv_y(conv_y_s), .conv_z(conv_z_s),
    .conv_done(conv_done_s),
    .cmp_valid(cmp_valid_s), .cmp_ready(cmp_ready_s), .cmp_id(cmp_id_s), .cmp_cycles(cmp_cycles_s),
    .busy(busy_s), .queue_count(queue_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input bit sel, input int budget);
    int n = 0;
    while (n < budget && (sel ? conv_start_s : conv_start) !== 1'b1) begin
      tick();
      n++;
    end
    chk(sel ? "start_s_seen" : "start_seen", 32'(sel ? conv_start_s : conv_start), 1);
  endtask

  task automatic push_job(input int x, input int y, input int z);
    req_valid = 1'b1;
    req_x = 7'(x);
    req_y = 7'(y);
    req_z = 7'(z);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_start"}, 32'(conv_start), 0);
    chk({tag, "_cmp_valid"}, 32'(cmp_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_qcount"}, 32'(queue_count), 0);
    chk({tag, "_req_ready"}, 32'(req_ready), 1);
    chk({tag, "_cmp_id"}, 32'(cmp_id), 0);
    chk({tag, "_cmp_cycles"}, 32'(cmp_cycles), 0);
    chk({tag, "_conv_xyz"}, 32'({conv_x, conv_y, conv_z}), 0);
  endtask

  // Narrow instance: one job, done edge d cycles after LAUNCH.
  task automatic run_job_s(input int j, input int d);
    int exp_cyc;
    exp_cyc = (d > 15) ? 15 : d;
    req_valid_s = 1'b1;
    req_x_s = 7'(40 + j);
    req_y_s = 7'(50 + j);
    req_z_s = 7'(60 + j);
    tick();
    req_valid_s = 1'b0;
    wait_start(1'b1, 10);
    chk("s_conv_x", 32'(conv_x_s), 40 + j);
    repeat (d) tick();
    conv_done_s = 1'b1;
    tick();
    conv_done_s = 1'b0;
    chk("s_cmp_valid", 32'(cmp_valid_s), 1);
    chk("s_cmp_id", 32'(cmp_id_s), j % 4);
    chk("s_cmp_cycles", 32'(cmp_cycles_s), exp_cyc);
    cmp_ready_s = 1'b1;
    tick();
    cmp_ready_s = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_x = '0; req_y = '0; req_z = '0;
    conv_done = 1'b0; cmp_ready = 1'b0;
    req_valid_s = 1'b0; req_x_s = '0; req_y_s = '0; req_z_s = '0;
    conv_done_s = 1'b0; cmp_ready_s = 1'b0;

    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Single job: push in cycle 0, launch in cycle 2, done 37 cycles after launch.
    push_job(10, 20, 30);
    chk("single_qcount_c1", 32'(queue_count), 1);
    chk("single_nostart_c1", 32'(conv_start), 0);
    tick();
    chk("single_start_c2", 32'(conv_start), 1);
    chk("single_x", 32'(conv_x), 10);
    chk("single_y", 32'(conv_y), 20);
    chk("single_z", 32'(conv_z), 30);
    chk("single_busy", 32'(busy), 1);
    chk("single_qcount_c2", 32'(queue_count), 0);
    tick();
    chk("single_start_1cyc", 32'(conv_start), 0);
    repeat (35) tick();
    chk("single_no_early_cmp", 32'(cmp_valid), 0);
    tick();
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    chk("single_cmp_valid", 32'(cmp_valid), 1);
    chk("single_cmp_id", 32'(cmp_id), 0);
    chk("single_cmp_cycles", 32'(cmp_cycles), 37);
    cmp_ready = 1'b1;
    tick();
    cmp_ready = 1'b0;
    chk("single_cmp_drop", 32'(cmp_valid), 0);
    chk("single_idle", 32'(busy), 0);

    // Fill FIFO: 5 back-to-back jobs while the engine is held busy.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      chk("fill_ready", 32'(req_ready), 1);
      req_valid = 1'b1;
      req_x = 7'(i + 1);
      req_y = 7'(i + 17);
      req_z = 7'(i + 33);
      tick();
    end
    req_x = 7'd99;
    chk("fill_qcount_full", 32'(queue_count), 4);
    chk("fill_ready_low", 32'(req_ready), 0);
    tick();
    req_valid = 1'b0;
    chk("fill_no_overpush", 32'(queue_count), 4);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) begin
        wait_start(1'b0, 20);
        chk("fill_qcount_launch", 32'(queue_count), 4 - j);
        tick();
      end
      chk("fill_x", 32'(conv_x), j + 1);
      chk("fill_y", 32'(conv_y), j + 17);
      chk("fill_z", 32'(conv_z), j + 33);
      conv_done = 1'b1;
      tick();
      conv_done = 1'b0;
      chk("fill_cmp_valid", 32'(cmp_valid), 1);
      chk("fill_cmp_id", 32'(cmp_id), j);
      cmp_ready = 1'b1;
      tick();
      cmp_ready = 1'b0;
    end

    // Stuck done level across REPORT -> LAUNCH (ids 5 and 6).
    push_job(1, 2, 3);
    push_job(4, 5, 6);
    chk("stuck_start_a", 32'(conv_start), 1);
    tick();
    conv_done = 1'b1;
    tick();
    chk("stuck_cmp_a", 32'(cmp_valid), 1);
    chk("stuck_id_a", 32'(cmp_id), 5);
    cmp_ready = 1'b1;
    tick();
    cmp_ready = 1'b0;
    tick();
    chk("stuck_start_b", 32'(conv_start), 1);
    chk("stuck_x_b", 32'(conv_x), 4);
    repeat (5) begin
      tick();
      chk("stuck_no_cmp", 32'(cmp_valid), 0);
    end
    conv_done = 1'b0;
    tick();
    chk("stuck_no_cmp_low", 32'(cmp_valid), 0);
    conv_done = 1'b1;
    tick();
    chk("stuck_cmp_b", 32'(cmp_valid), 1);
    chk("stuck_id_b", 32'(cmp_id), 6);
    chk("stuck_cycles_b", 32'(cmp_cycles), 6);
    conv_done = 1'b0;
    cmp_ready = 1'b1;
    tick();
    cmp_ready = 1'b0;

    // Completion back-pressure (ids 7 and 8).
    push_job(11, 12, 13);
    push_job(14, 15, 16);
    chk("bp_start_c", 32'(conv_start), 1);
    tick();
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    chk("bp_qcount", 32'(queue_count), 1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(cmp_valid), 1);
      chk("bp_id", 32'(cmp_id), 7);
      chk("bp_cycles", 32'(cmp_cycles), 1);
      chk("bp_no_start", 32'(conv_start), 0);
      chk("bp_x_hold", 32'(conv_x), 11);
      tick();
    end
    cmp_ready = 1'b1;
    tick();
    cmp_ready = 1'b0;
    chk("bp_cmp_drop", 32'(cmp_valid), 0);
    chk("bp_no_start_k1", 32'(conv_start), 0);
    tick();
    chk("bp_start_k2", 32'(conv_start), 1);
    chk("bp_x_d", 32'(conv_x), 14);
    tick();
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    chk("bp_id_d", 32'(cmp_id), 8);
    cmp_ready = 1'b1;
    tick();
    cmp_ready = 1'b0;

    // Asynchronous reset in the middle of WAIT with one job still queued.
    push_job(21, 22, 23);
    push_job(24, 25, 26);
    repeat (3) tick();
    chk("mid_busy_pre", 32'(busy), 1);
    #3;
    rst = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    @(negedge clk);
    rst = 1'b1;
    tick();
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    repeat (3) begin
      tick();
      chk("post_rst_cmp", 32'(cmp_valid), 0);
      chk("post_rst_busy", 32'(busy), 0);
      chk("post_rst_qcount", 32'(queue_count), 0);
      chk("post_rst_start", 32'(conv_start), 0);
    end

    // Narrow instance: id wraps on the 5th job, cycle count saturates at 15.
    for (int j = 0; j < 5; j++) begin
      run_job_s(j, (j == 4) ? 20 : 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_job_scheduler.md
# conv_job_scheduler

Job-level scheduler in front of the `convolution` engine. It accepts convolution jobs (X, Y, Z base addresses) from a host over a valid/ready port and buffers them in a small FIFO. It launches jobs one at a time on the engine's `start`/`done` pins and holds the addresses stable for the whole job. It returns one completion record per job, carrying a job id and a measured cycle count.

## Interface
Parameters:
- `ADDR_W`, 7: width of X/Y/Z addresses; matches engine ports.
- `DEPTH`, 4: job FIFO depth; power of two, ≥2.
- `ID_W`, 4: job id width; ids wrap mod 2^ID_W.
- `CYC_W`, 16: cycle counter width; saturating.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  host offers a job.
- `req_ready`  out  1  job accepted when `req_valid & req_ready`.
- `req_x`, `req_y`, `req_z`  in  ADDR_W each  job addresses.
- `conv_start`  out  1  one-cycle launch pulse to engine `start`.
- `conv_x`, `conv_y`, `conv_z`  out  ADDR_W each  to engine X/Y/Z; stable from launch until completion.
- `conv_done`  in  1  engine `done` (pulse or level).
- `cmp_valid`  out  1  completion record available.
- `cmp_ready`  in  1  host consumes record.
- `cmp_id`  out  ID_W  id of completed job.
- `cmp_cycles`  out  CYC_W  engine cycles for that job.
- `busy`  out  1  high in any state but IDLE.
- `queue_count`  out  $clog2(DEPTH)+1  jobs waiting in FIFO.

## Operation
- **Accept.**
  - `req_ready = (queue_count != DEPTH)`.
  - On handshake, push {next_id, x, y, z}, then increment next_id.
  - next_id resets to 0.
- **FSM states:** IDLE, LAUNCH, WAIT, REPORT.
  - **IDLE:** if FIFO non-empty, pop the head into hold registers (drive `conv_x/y/z`, id), then go to LAUNCH. Otherwise stay.
  - **LAUNCH:** `conv_start=1` for exactly this cycle. Cycle counter cleared to 0. Go to WAIT.
  - **WAIT:** counter increments by 1 per cycle, saturating at 2^CYC_W−1. When a rising edge of `conv_done` is detected (`conv_done & ~done_q`), go to REPORT.
  - **REPORT:** `cmp_valid=1`, with `cmp_id`/`cmp_cycles` stable until `cmp_ready`. On handshake, go to IDLE.
- `done_q` is registered every cycle (reset 0). A `done` level already high from the previous job does not complete the next job; a fresh rising edge is required.
- `conv_done` edges outside WAIT are ignored.
- `conv_x/y/z` change only in the IDLE pop cycle.
- Push and pop in the same cycle: `queue_count` unchanged. A push when full is impossible by construction, because `req_ready` is low; there is no full-bypass.
- Reset mid-job: all state cleared and FIFO emptied. The engine shares the same reset; no partial completion record is emitted.

## Timing
- Reset values:
  - `conv_start`, `cmp_valid`, `busy`, `queue_count`, `cmp_id`, `cmp_cycles`, `conv_x/y/z`: all 0.
  - `req_ready`: 1.
- Launch latency: a request handshake in cycle n puts `conv_start` high in cycle n+2, when the FIFO was empty and the FSM was IDLE.
- `cmp_cycles`: number of WAIT cycles, from the cycle after LAUNCH up to and including the cycle the `done` edge is seen.
- Completion latency: the `done` edge in cycle m gives `cmp_valid` high in cycle m+1.
- Inter-job gap: REPORT handshake in cycle k, then IDLE pop in k+1, then next `conv_start` in k+2.
- `cmp_valid` never drops without `cmp_ready`. Back-pressure on `cmp_ready` stalls further launches; the FIFO keeps accepting until full.

## Structure
- Package `conv_sched_pkg`: state encoding (IDLE, LAUNCH, WAIT, REPORT), default widths, and the FIFO entry width `3*ADDR_W+ID_W`.
- Sub-module `job_fifo`:
  - synchronous FIFO with parameters DEPTH and WIDTH;
  - push/pop/full/empty/count;
  - asynchronous active-low reset.
- Top level holds the FSM, hold registers, id counter, cycle counter and `done` edge detector.

## Test plan
- **Single job:** after reset, push (X=10, Y=20, Z=30) in cycle 0.
  - Required: `conv_start` in cycle 2 with `conv_x/y/z` = 10/20/30.
  - Drive a `done` pulse 37 cycles after LAUNCH. Required: `cmp_valid` with `cmp_id`=0, `cmp_cycles`=37.
- **Fill FIFO:** push 5 jobs back-to-back while the engine is held busy.
  - Required: `req_ready` drops after the 4th queued job; `queue_count`=4.
  - Jobs complete in order with ids 0..4 and addresses unchanged.
- **Stuck done level:** hold `conv_done` high across a REPORT→LAUNCH transition.
  - Required: the next job does not complete until `done` falls and rises again.
- **Completion back-pressure:** hold `cmp_ready` low for 10 cycles.
  - Required: the record stays stable and no `conv_start` is issued; the pending launch occurs 2 cycles after the handshake.
- **Wrap and saturate:** with `ID_W`=2, run 5 jobs; required: 5th `cmp_id`=0. With `CYC_W`=4 and done at 20 cycles; required: `cmp_cycles`=15.
- **Reset mid-WAIT:** assert `rst` low asynchronously.
  - Required: all outputs return to reset values immediately; FIFO empty; no completion record emitted.
